// File: rtl/lif_pkg.sv
// ---------------------------------------------------------------------------
// lif_pkg
//   Shared types and arithmetic helpers for the leaky-integrate-and-fire array.
//   - leak_sel_e : per-channel leak select encoding
//   - sat_add    : unsigned add saturating to 2**w-1
//   - leak       : leak term L(U) for a given select
//   Helpers operate on MAX_W-bit operands; callers zero-extend their W-bit
//   values in and cast the result back to W bits (W must be < MAX_W).
// ---------------------------------------------------------------------------
package lif_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    LEAK_125 = 2'd0,  // U>>3
    LEAK_500 = 2'd1,  // U>>1
    LEAK_750 = 2'd2,  // (U>>1)+(U>>2)
    LEAK_875 = 2'd3   // (U>>1)+(U>>2)+(U>>3)
  } leak_sel_e;

  // a + b clamped to 2**w-1. The sum is formed one bit wider than the
  // operands so the carry is never lost before the clamp.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] lim;
    s   = (MAX_W+1)'(a) + (MAX_W+1)'(b);
    lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    if (s > lim)
      return MAX_W'(lim);
    else
      return MAX_W'(s);
  endfunction

  // Leak term: the portion of U that survives into the next tick.
  // For U < 2**w the result is < 2*U's top bit range, so it stays below 2**w.
  function automatic logic [MAX_W-1:0] leak(input logic [MAX_W-1:0] u,
                                            input leak_sel_e sel);
    logic [MAX_W-1:0] r;
    case (sel)
      LEAK_125: r = u >> 3;
      LEAK_500: r = u >> 1;
      LEAK_750: r = (u >> 1) + (u >> 2);
      default:  r = (u >> 1) + (u >> 2) + (u >> 3);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lif_cell.sv
// ---------------------------------------------------------------------------
// lif_cell
//   One leaky-integrate-and-fire neuron with refractory hold and an adaptive
//   threshold offset b. Updates only on cycles where en=1.
// Ports
//   clk       in  1   clock (posedge)
//   rst_n     in  1   synchronous active-low reset, overrides en
//   en        in  1   tick strobe
//   current   in  W   input current for this tick
//   leak_sel  in  2   leak select (lif_pkg::leak_sel_e encoding)
//   adapt_en  in  1   0 = offset b cleared on every tick
//   spike     out 1   one-clk spike pulse
//   state     out W   membrane potential U
//   thresh    out W   effective threshold min(THRESH0 + b, 2**W-1)
// ---------------------------------------------------------------------------
module lif_cell
  import lif_pkg::*;
#(
  parameter int W           = 8,
  parameter int THRESH0     = 230,
  parameter int REFRAC      = 2,
  parameter int ADAPT_INC   = 16,
  parameter int ADAPT_SHIFT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] current,
  input  logic [1:0]   leak_sel,
  input  logic         adapt_en,
  output logic         spike,
  output logic [W-1:0] state,
  output logic [W-1:0] thresh
);

  // Counter just wide enough to hold REFRAC; one bit minimum when REFRAC=0.
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [W-1:0]  state_reg, state_next;
  logic [W-1:0]  b_reg, b_next;
  logic [RW-1:0] refrac_reg, refrac_next;
  logic          spike_reg, spike_next;

  logic [W-1:0]  leak_val;
  logic [W-1:0]  sum_sat;
  logic [W-1:0]  theta;
  logic [W-1:0]  b_inc;
  logic [W-1:0]  b_decay;

  // Datapath. The leaked potential plus current can exceed W bits, so it is
  // clamped to 2**W-1; a clamped sum still fires against a clamped theta.
  always_comb begin
    leak_val = W'(leak(MAX_W'(state_reg), leak_sel_e'(leak_sel)));
    sum_sat  = W'(sat_add(MAX_W'(leak_val), MAX_W'(current), W));
    theta    = W'(sat_add(MAX_W'(THRESH0), MAX_W'(b_reg), W));
    b_inc    = W'(sat_add(MAX_W'(b_reg), MAX_W'(ADAPT_INC), W));
    // Subtracting a right-shifted copy of itself can never underflow.
    b_decay  = b_reg - (b_reg >> ADAPT_SHIFT);
  end

  always_comb begin
    state_next  = state_reg;
    b_next      = b_reg;
    refrac_next = refrac_reg;
    spike_next  = 1'b0;
    if (en) begin
      if (refrac_reg != '0) begin
        state_next  = '0;
        refrac_next = refrac_reg - RW'(1);
        b_next      = b_decay;
      end else if (sum_sat >= theta) begin
        // Firing tick: raise the threshold offset, skip this tick's decay.
        spike_next  = 1'b1;
        state_next  = '0;
        refrac_next = RW'(REFRAC);
        b_next      = b_inc;
      end else begin
        state_next  = sum_sat;
        b_next      = b_decay;
      end
      if (!adapt_en)
        b_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= '0;
      b_reg      <= '0;
      refrac_reg <= '0;
      spike_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      b_reg      <= b_next;
      refrac_reg <= refrac_next;
      spike_reg  <= spike_next;
    end
  end

  assign spike  = spike_reg;
  assign state  = state_reg;
  assign thresh = theta;

endmodule

// File: rtl/lif_array.sv
// ---------------------------------------------------------------------------
// lif_array
//   N independent leaky-integrate-and-fire neurons. Pure port slicing around
//   N lif_cell instances; channels share nothing but clock, reset, en and
//   adapt_en.
// Ports
//   clk       in  1     clock (posedge)
//   rst_n     in  1     synchronous active-low reset
//   en        in  1     tick strobe
//   current   in  N*W   channel i current at [i*W +: W]
//   leak_sel  in  2*N   channel i leak select at [2i +: 2]
//   adapt_en  in  1     adaptive threshold enable
//   spike     out N     per-channel one-clk spike
//   state     out N*W   per-channel membrane potential
//   thresh    out N*W   per-channel effective threshold
// ---------------------------------------------------------------------------
module lif_array
  import lif_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int THRESH0     = 230,
  parameter int REFRAC      = 2,
  parameter int ADAPT_INC   = 16,
  parameter int ADAPT_SHIFT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N*W-1:0] current,
  input  logic [2*N-1:0] leak_sel,
  input  logic           adapt_en,
  output logic [N-1:0]   spike,
  output logic [N*W-1:0] state,
  output logic [N*W-1:0] thresh
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      lif_cell #(
        .W          (W),
        .THRESH0    (THRESH0),
        .REFRAC     (REFRAC),
        .ADAPT_INC  (ADAPT_INC),
        .ADAPT_SHIFT(ADAPT_SHIFT)
      ) u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .current (current[gi*W +: W]),
        .leak_sel(leak_sel[2*gi +: 2]),
        .adapt_en(adapt_en),
        .spike   (spike[gi]),
        .state   (state[gi*W +: W]),
        .thresh  (thresh[gi*W +: W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_lif_array.sv
// ---------------------------------------------------------------------------
// tb_lif_array
//   Directed and randomized stimulus for lif_array, checked every clock
//   against an integer reference model of each neuron, plus literal expected
//   values for the hand-worked sequences.
// ---------------------------------------------------------------------------
module tb_lif_array;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int TH0  = 230;
  localparam int REF  = 2;
  localparam int AINC = 16;
  localparam int MAXV = 255;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           adapt_en;
  logic [N*W-1:0] current;
  logic [2*N-1:0] leak_sel;
  logic [N-1:0]   spike;
  logic [N*W-1:0] state;
  logic [N*W-1:0] thresh;

  always #5 clk = ~clk;

  lif_array #(
    .N(N), .W(W), .THRESH0(TH0), .REFRAC(REF), .ADAPT_INC(AINC), .ADAPT_SHIFT(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .current (current),
    .leak_sel(leak_sel),
    .adapt_en(adapt_en),
    .spike   (spike),
    .state   (state),
    .thresh  (thresh)
  );

  // stimulus per channel
  int cur[N];
  int sel[N];
  // reference model: potential, offset, refractory ticks left, spike
  int mu[N], mb[N], mr[N], ms[N];

  int n_vec = 0;
  int n_err = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // fraction of U kept: 1/8, 1/2, 3/4, 7/8 (each term floored separately)
  function automatic int leak_m(int u, int s);
    case (s)
      0:       return u / 8;
      1:       return u / 2;
      2:       return u / 2 + u / 4;
      default: return u / 2 + u / 4 + u / 8;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        mu[i] = 0; mb[i] = 0; mr[i] = 0; ms[i] = 0;
      end else if (!en) begin
        ms[i] = 0;
      end else begin
        int th;
        int sum;
        th = imin(TH0 + mb[i], MAXV);
        if (mr[i] > 0) begin
          mu[i] = 0; ms[i] = 0; mr[i] = mr[i] - 1;
          mb[i] = mb[i] - mb[i] / 8;
        end else begin
          sum = imin(leak_m(mu[i], sel[i]) + cur[i], MAXV);
          if (sum >= th) begin
            ms[i] = 1; mu[i] = 0; mr[i] = REF;
            mb[i] = imin(mb[i] + AINC, MAXV);
          end else begin
            ms[i] = 0; mu[i] = sum;
            mb[i] = mb[i] - mb[i] / 8;
          end
        end
        if (!adapt_en) mb[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s.state[%0d]", tag, i), 32'(state[i*W +: W]), 32'(mu[i]));
      check($sformatf("%s.spike[%0d]", tag, i), 32'(spike[i]), 32'(ms[i]));
      check($sformatf("%s.thresh[%0d]", tag, i), 32'(thresh[i*W +: W]),
            32'(imin(TH0 + mb[i], MAXV)));
    end
  endtask

  // one clock: drive at negedge, model on posedge, compare 1 time unit later
  task automatic cycle(input string tag);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      current[i*W +: W]  = W'(cur[i]);
      leak_sel[2*i +: 2] = 2'(sel[i]);
    end
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
    $display("[%0t] %s rst_n=%0b en=%0b adapt=%0b spike=%b st0=%0d th0=%0d",
             $time, tag, rst_n, en, adapt_en, spike, state[W-1:0], thresh[W-1:0]);
  endtask

  task automatic check_ch0(input string tag, input int es, input int esp, input int eth);
    check({tag, ".ch0_state"},  32'(state[W-1:0]),  32'(es));
    check({tag, ".ch0_spike"},  32'(spike[0]),      32'(esp));
    check({tag, ".ch0_thresh"}, 32'(thresh[W-1:0]), 32'(eth));
  endtask

  task automatic set_all(input int c, input int s);
    for (int i = 0; i < N; i++) begin
      cur[i] = c; sel[i] = s;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle("rst");
    rst_n = 1'b1;
  endtask

  int exp_st2[8]  = '{120, 180, 210, 225, 0, 0, 0, 120};
  int exp_sp2[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
  int exp_st4[5]  = '{0, 0, 0, 240, 0};
  int exp_sp4[5]  = '{1, 0, 0, 0, 1};
  int exp_th4[5]  = '{246, 244, 243, 242, 255};

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    adapt_en = 1'b1;
    current  = '0;
    leak_sel = '0;
    for (int i = 0; i < N; i++) begin
      mu[i] = 0; mb[i] = 0; mr[i] = 0; ms[i] = 0;
    end

    // 1. reset dominates en with maximum current
    set_all(255, 3);
    for (int k = 0; k < 3; k++) cycle("reset");
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset.state[%0d]", i),  32'(state[i*W +: W]),  32'd0);
      check($sformatf("reset.spike[%0d]", i),  32'(spike[i]),         32'd0);
      check($sformatf("reset.thresh[%0d]", i), 32'(thresh[i*W +: W]), 32'd230);
    end

    // 2./3. integrate, fire, refractory, integrate again on ch0
    rst_n = 1'b1; adapt_en = 1'b0;
    set_all(0, 0);
    cur[0] = 120; sel[0] = 1;
    for (int k = 0; k < 8; k++) begin
      cycle($sformatf("intfire_t%0d", k + 1));
      check_ch0($sformatf("intfire_t%0d", k + 1), exp_st2[k], exp_sp2[k], 230);
    end

    // 4. adaptive threshold, including theta saturation
    do_reset();
    adapt_en = 1'b1;
    set_all(0, 0);
    cur[0] = 240; sel[0] = 0;
    for (int k = 0; k < 5; k++) begin
      cycle($sformatf("adapt_t%0d", k + 1));
      check_ch0($sformatf("adapt_t%0d", k + 1), exp_st4[k], exp_sp4[k], exp_th4[k]);
    end

    // 5. en gating mid-integration (ch1 fires first so its theta is non-base)
    do_reset();
    set_all(0, 0);
    cur[0] = 60;  sel[0] = 1;
    cur[1] = 255; sel[1] = 2;
    cycle("gate_t1");
    cycle("gate_t2");
    check_ch0("gate_t2", 90, 0, 230);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle($sformatf("gate_hold%0d", k));
      check_ch0($sformatf("gate_hold%0d", k), 90, 0, 230);
    end
    en = 1'b1;
    cycle("gate_resume");
    check_ch0("gate_resume", 105, 0, 230);

    // 6. channel independence with mixed leak selects
    do_reset();
    cur[0] = 0;   sel[0] = 0;
    cur[1] = 60;  sel[1] = 1;
    cur[2] = 120; sel[2] = 2;
    cur[3] = 255; sel[3] = 3;
    for (int k = 0; k < 12; k++) begin
      cycle($sformatf("indep_t%0d", k + 1));
      // ch3 fires on every third tick starting with the first
      check($sformatf("indep_t%0d.ch3_fire", k + 1), 32'(spike[3]), 32'((k % 3) == 0));
      check($sformatf("indep_t%0d.ch0_zero", k + 1), 32'(state[W-1:0]), 32'd0);
    end

    // 7. randomized traffic with occasional resets and adapt toggles
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en    = ($urandom_range(0, 9) < 7);
      if ((k % 40) == 0) adapt_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        cur[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
        sel[i] = int'($urandom_range(0, 3));
      end
      cycle($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
